pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 79 +++++++
 tb/tb_pipe_stage_skid.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: IF/ID pipeline register with 2-entry skid buffer, flush, and saturating stall/flush counters
module pipe_stage_skid #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t            state;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic              acc;
    logic              fire;
    assign out_valid = state != EMPTY;
    assign in_ready  = state != TWO;
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_inst  <= NOP_INST;
            out_pc    <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && state != EMPTY && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (flush) begin
                state    <= EMPTY;
                out_inst <= NOP_INST;
                out_pc   <= '0;
            end else begin
                case (state)
                    EMPTY: if (acc) begin
                        state    <= ONE;
                        out_inst <= in_inst;
                        out_pc   <= in_pc;
                    end
                    ONE: if (acc && fire) begin
                        out_inst <= in_inst;
                        out_pc   <= in_pc;
                    end else if (acc) begin
                        state     <= TWO;
                        skid_inst <= in_inst;
                        skid_pc   <= in_pc;
                    end else if (fire) begin
                        state    <= EMPTY;
                        out_inst <= NOP_INST;
                        out_pc   <= '0;
                    end
                    TWO: if (fire) begin
                        state    <= ONE;
                        out_inst <= skid_inst;
                        out_pc   <= skid_pc;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven and scoreboard checks of pipe_stage_skid
module tb_pipe_stage_skid;
    localparam logic [31:0] NOP = 32'h00000013;
    typedef struct {
        logic        rst, iv, fl, ordy;
        logic [31:0] pc;
        logic        e_ov, e_ir;
        logic [31:0] e_pc;
        logic [15:0] e_st, e_fl;
    } vec_t;
    typedef struct {
        logic [31:0] inst, pc;
    } ent_t;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_inst, out_pc;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_inst, s_out_pc;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    int          n_cmp = 0, n_bad = 0;
    logic        exp_rdy = 1;
    ent_t        sb[$];
    vec_t        tbl[$];

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    pipe_stage_skid #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, iv, input logic [31:0] pc, input logic fl, ordy,
                       input logic eov, eir, input logic [31:0] epc, input logic [15:0] est, efl);
        vec_t v;
        v.rst = r; v.iv = iv; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.e_ov = eov; v.e_ir = eir; v.e_pc = epc; v.e_st = est; v.e_fl = efl;
        tbl.push_back(v);
    endtask

    task automatic cyc(input vec_t v);
        ent_t e;
        @(negedge clk);
        rst = v.rst; in_valid = v.iv; in_pc = v.pc; in_inst = mk(v.pc);
        flush = v.fl; out_ready = v.ordy;
        if (out_valid && v.ordy) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_underflow: got pc %0h expected no output", out_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_inst", out_inst, e.inst);
                chk("sb_pc", out_pc, e.pc);
            end
        end
        if (v.rst || v.fl) sb.delete();
        else if (v.iv && exp_rdy) begin
            e.inst = mk(v.pc); e.pc = v.pc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_rdy = v.e_ir;
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        chk($sformatf("r%0d_out_valid", i), out_valid, v.e_ov);
        chk($sformatf("r%0d_in_ready", i), in_ready, v.e_ir);
        chk($sformatf("r%0d_out_pc", i), out_pc, v.e_pc);
        chk($sformatf("r%0d_out_inst", i), out_inst, v.e_ov ? mk(v.e_pc) : NOP);
        chk($sformatf("r%0d_stall_cnt", i), stall_cnt, v.e_st);
        chk($sformatf("r%0d_flush_cnt", i), flush_cnt, v.e_fl);
    endtask

    initial begin
        vec_t v;
        //  rst iv pc        fl ordy  ov ir pc         st fl
        add(1, 0, 32'h00, 0, 0,   0, 1, 32'h00,   0, 0);
        add(0, 1, 32'h00, 0, 1,   1, 1, 32'h00,   0, 0);
        add(0, 1, 32'h04, 0, 1,   1, 1, 32'h04,   0, 0);
        add(0, 1, 32'h08, 0, 1,   1, 1, 32'h08,   0, 0);
        add(0, 1, 32'h0C, 0, 1,   1, 1, 32'h0C,   0, 0);
        add(0, 0, 32'h00, 0, 1,   0, 1, 32'h00,   0, 0);
        add(0, 1, 32'h10, 0, 1,   1, 1, 32'h10,   0, 0);
        add(0, 1, 32'h14, 0, 0,   1, 0, 32'h10,   1, 0);
        add(0, 1, 32'h18, 0, 0,   1, 0, 32'h10,   2, 0);
        add(0, 0, 32'h00, 0, 1,   1, 1, 32'h14,   2, 0);
        add(0, 0, 32'h00, 0, 1,   0, 1, 32'h00,   2, 0);
        add(0, 1, 32'h20, 0, 0,   1, 1, 32'h20,   2, 0);
        add(0, 1, 32'h24, 0, 0,   1, 0, 32'h20,   3, 0);
        add(0, 1, 32'h40, 1, 0,   0, 1, 32'h00,   4, 1);
        add(0, 0, 32'h00, 1, 0,   0, 1, 32'h00,   4, 1);
        add(0, 0, 32'h00, 0, 1,   0, 1, 32'h00,   4, 1);
        add(0, 1, 32'h50, 0, 1,   1, 1, 32'h50,   4, 1);
        add(0, 1, 32'h54, 1, 1,   0, 1, 32'h00,   4, 2);
        add(0, 1, 32'h60, 0, 0,   1, 1, 32'h60,   4, 2);
        add(0, 1, 32'h64, 0, 0,   1, 0, 32'h60,   5, 2);
        add(1, 1, 32'h68, 1, 0,   0, 1, 32'h00,   0, 0);
        add(0, 1, 32'h70, 0, 0,   1, 1, 32'h70,   0, 0);
        foreach (tbl[i]) begin
            cyc(tbl[i]);
            chk_vec(i, tbl[i]);
        end
        chk("sat_reset_stall", s_stall_cnt, 4'd0);
        chk("sat_reset_flush", s_flush_cnt, 4'd0);
        v = tbl[tbl.size()-1];
        v.iv = 0; v.ordy = 0; v.e_ir = 1;
        for (int k = 1; k <= 20; k++) begin
            cyc(v);
            if (k == 15 || k == 20) begin
                chk($sformatf("sat_stall_%0d", k), s_stall_cnt, 4'd15);
                chk($sformatf("full_stall_%0d", k), stall_cnt, 16'(k));
                chk($sformatf("sat_hold_pc_%0d", k), s_out_pc, 32'h70);
            end
        end
        v.ordy = 1;
        cyc(v);
        chk("drain_out_valid", out_valid, 1'b0);
        chk("drain_sat_stall", s_stall_cnt, 4'd15);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        for (int k = 0; k < 8; k++) begin
            v.iv = 1; v.pc = 32'h100 + 32'(k * 4); v.ordy = 1;
            cyc(v);
            chk($sformatf("tp_pc_%0d", k), out_pc, v.pc);
            chk($sformatf("tp_in_ready_%0d", k), in_ready, 1'b1);
        end
        v.iv = 0;
        cyc(v);
        chk("tp_end_out_valid", out_valid, 1'b0);
        chk("tp_end_stall", stall_cnt, 16'd20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
